// File: rtl/win_detector.sv
// Three-in-a-row win detector: snapshots a committed board, scans the eight
// winning lines one per clock and holds the registered verdict until cleared.
module win_detector #(
  parameter bit EARLY_EXIT  = 1'b1,
  parameter bit DRAW_ENABLE = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [8:0] board_p1_i,
  input  logic [8:0] board_p2_i,
  input  logic       board_valid_i,
  input  logic       clear_game_i,
  output logic [1:0] detect_win_o,
  output logic [2:0] win_line_o,
  output logic       busy_o,
  output logic       done_o,
  output logic       game_over_o
);

  typedef enum logic [1:0] {StIdle, StScan, StFinish, StHold} state_e;

  state_e     state_q;
  logic [2:0] idx_q;
  logic [8:0] p1_q, p2_q;
  logic [1:0] rec_res_q;
  logic [2:0] rec_line_q;
  logic [1:0] detect_q;
  logic [2:0] line_q;
  logic       busy_q, done_q;

  logic [8:0] mask;
  logic [1:0] line_res_d;
  logic       board_full;

  function automatic logic [8:0] line_mask(input logic [2:0] idx);
    logic [8:0] m;
    unique case (idx)
      3'd0: m = 9'b000_000_111;
      3'd1: m = 9'b000_111_000;
      3'd2: m = 9'b111_000_000;
      3'd3: m = 9'b001_001_001;
      3'd4: m = 9'b010_010_010;
      3'd5: m = 9'b100_100_100;
      3'd6: m = 9'b100_010_001;
      3'd7: m = 9'b001_010_100;
      default: m = 9'b000_000_000;
    endcase
    return m;
  endfunction

  // Player 1 wins ties when both players fully occupy the same line.
  always_comb begin
    mask       = line_mask(idx_q);
    line_res_d = 2'b00;
    if ((p1_q & mask) == mask) begin
      line_res_d = 2'b01;
    end else if ((p2_q & mask) == mask) begin
      line_res_d = 2'b10;
    end
    board_full = &(p1_q | p2_q);
  end

  // A line evaluated on one edge is recorded, then acted on the following edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      idx_q      <= 3'd0;
      p1_q       <= 9'd0;
      p2_q       <= 9'd0;
      rec_res_q  <= 2'b00;
      rec_line_q <= 3'd0;
      detect_q   <= 2'b00;
      line_q     <= 3'd0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (clear_game_i) begin
        state_q    <= StIdle;
        detect_q   <= 2'b00;
        line_q     <= 3'd0;
        busy_q     <= 1'b0;
        rec_res_q  <= 2'b00;
        rec_line_q <= 3'd0;
      end else begin
        unique case (state_q)
          StIdle: begin
            if (board_valid_i) begin
              p1_q       <= board_p1_i;
              p2_q       <= board_p2_i;
              idx_q      <= 3'd0;
              rec_res_q  <= 2'b00;
              rec_line_q <= 3'd0;
              busy_q     <= 1'b1;
              state_q    <= StScan;
            end
          end
          StScan: begin
            if (EARLY_EXIT && (rec_res_q != 2'b00)) begin
              detect_q <= rec_res_q;
              line_q   <= rec_line_q;
              done_q   <= 1'b1;
              busy_q   <= 1'b0;
              state_q  <= StHold;
            end else begin
              if ((rec_res_q == 2'b00) && (line_res_d != 2'b00)) begin
                rec_res_q  <= line_res_d;
                rec_line_q <= idx_q;
              end
              if (idx_q == 3'd7) begin
                state_q <= StFinish;
              end else begin
                idx_q <= idx_q + 3'd1;
              end
            end
          end
          StFinish: begin
            done_q <= 1'b1;
            busy_q <= 1'b0;
            if (rec_res_q != 2'b00) begin
              detect_q <= rec_res_q;
              line_q   <= rec_line_q;
              state_q  <= StHold;
            end else if (DRAW_ENABLE && board_full) begin
              detect_q <= 2'b11;
              line_q   <= 3'd0;
              state_q  <= StHold;
            end else begin
              state_q <= StIdle;
            end
          end
          StHold: begin
            state_q <= StHold;
          end
          default: state_q <= StIdle;
        endcase
      end
    end
  end

  assign detect_win_o = detect_q;
  assign win_line_o   = line_q;
  assign busy_o       = busy_q;
  assign done_o       = done_q;
  assign game_over_o  = (detect_q != 2'b00);

endmodule

// File: tb/tb_win_detector.sv
// Bench for win_detector: two instances (early-exit+draw, full-scan+no-draw)
// share stimulus; table vectors, random boards and reset/clear corner cases.
module tb_win_detector;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [8:0] board_p1 = '0;
  logic [8:0] board_p2 = '0;
  logic       board_valid = 1'b0;
  logic       clear_game = 1'b0;

  logic [1:0] dw_a, dw_b;
  logic [2:0] wl_a, wl_b;
  logic       busy_a, busy_b, done_a, done_b, go_a, go_b;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  win_detector #(.EARLY_EXIT(1'b1), .DRAW_ENABLE(1'b1)) u_dut_a (
    .clk(clk), .rst_n(rst_n), .board_p1_i(board_p1), .board_p2_i(board_p2),
    .board_valid_i(board_valid), .clear_game_i(clear_game),
    .detect_win_o(dw_a), .win_line_o(wl_a), .busy_o(busy_a), .done_o(done_a),
    .game_over_o(go_a)
  );

  win_detector #(.EARLY_EXIT(1'b0), .DRAW_ENABLE(1'b0)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .board_p1_i(board_p1), .board_p2_i(board_p2),
    .board_valid_i(board_valid), .clear_game_i(clear_game),
    .detect_win_o(dw_b), .win_line_o(wl_b), .busy_o(busy_b), .done_o(done_b),
    .game_over_o(go_b)
  );

  typedef struct {
    int         id;
    logic [8:0] p1;
    logic [8:0] p2;
    logic [1:0] res_a;
    logic [2:0] line_a;
    int         lat_a;
    logic [1:0] res_b;
    logic [2:0] line_b;
    int         lat_b;
  } vec_t;

  int cells [8][3] = '{'{0, 1, 2}, '{3, 4, 5}, '{6, 7, 8}, '{0, 3, 6},
                       '{1, 4, 7}, '{2, 5, 8}, '{0, 4, 8}, '{2, 4, 6}};

  // {busy, done, game_over, detect_win, win_line}
  function automatic logic [7:0] obs_a();
    return {busy_a, done_a, go_a, dw_a, wl_a};
  endfunction

  function automatic logic [7:0] obs_b();
    return {busy_b, done_b, go_b, dw_b, wl_b};
  endfunction

  function automatic logic [7:0] expect_at(input logic [1:0] res, input logic [2:0] line,
                                           input int lat, input int t);
    if (t < lat) return 8'b1000_0000;
    if (t == lat) return {1'b0, 1'b1, res != 2'b00, res, line};
    return {1'b0, 1'b0, res != 2'b00, res, line};
  endfunction

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got busy,done,go,dw,wl=%b required %b", name, act, exp);
    end
  endtask

  function automatic vec_t model(input int id, input logic [8:0] p1, input logic [8:0] p2);
    vec_t v;
    int hit = -1;
    logic [1:0] who = 2'b00;
    for (int k = 0; k < 8; k++) begin
      bit all1 = 1'b1;
      bit all2 = 1'b1;
      for (int c = 0; c < 3; c++) begin
        all1 &= p1[cells[k][c]];
        all2 &= p2[cells[k][c]];
      end
      if (hit < 0 && all1) begin
        hit = k; who = 2'b01;
      end else if (hit < 0 && all2) begin
        hit = k; who = 2'b10;
      end
    end
    v.id = id; v.p1 = p1; v.p2 = p2;
    v.lat_b = 9;
    if (hit >= 0) begin
      v.res_a = who; v.line_a = 3'(hit); v.lat_a = 2 + hit;
      v.res_b = who; v.line_b = 3'(hit);
    end else begin
      v.res_a = (&(p1 | p2)) ? 2'b11 : 2'b00;
      v.line_a = 3'd0; v.lat_a = 9;
      v.res_b = 2'b00; v.line_b = 3'd0;
    end
    return v;
  endfunction

  task automatic clear_and_check();
    @(negedge clk);
    clear_game = 1'b1;
    @(posedge clk); #1;
    clear_game = 1'b0;
    check("clear_a", obs_a(), 8'h00);
    check("clear_b", obs_b(), 8'h00);
  endtask

  // Boards change right after capture; mid_valid also re-pulses board_valid mid-scan/hold.
  task automatic run_vec(input vec_t v, input bit mid_valid);
    @(negedge clk);
    board_p1 = v.p1;
    board_p2 = v.p2;
    board_valid = 1'b1;
    @(posedge clk); #1;
    board_valid = 1'b0;
    board_p1 = 9'($urandom);
    board_p2 = 9'($urandom);
    for (int t = 0; t <= 10; t++) begin
      check($sformatf("vec%0d_a_t%0d", v.id, t), obs_a(), expect_at(v.res_a, v.line_a, v.lat_a, t));
      check($sformatf("vec%0d_b_t%0d", v.id, t), obs_b(), expect_at(v.res_b, v.line_b, v.lat_b, t));
      if (mid_valid && t == 3) begin
        board_p1 = 9'h1FF;
        board_p2 = 9'h000;
        board_valid = 1'b1;
      end else begin
        board_valid = 1'b0;
      end
      @(posedge clk); #1;
    end
    board_valid = 1'b0;
    clear_and_check();
  endtask

  task automatic start_long_scan();
    @(negedge clk);
    board_p1 = 9'b000_000_011;
    board_p2 = 9'b001_010_100;
    board_valid = 1'b1;
    @(posedge clk); #1;
    board_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
  endtask

  vec_t tbl [7];

  initial begin
    tbl[0] = '{1, 9'b000_000_111, 9'b000_011_000, 2'b01, 3'd0, 2, 2'b01, 3'd0, 9};
    tbl[1] = '{2, 9'b000_000_011, 9'b001_010_100, 2'b10, 3'd7, 9, 2'b10, 3'd7, 9};
    tbl[2] = '{3, 9'b101_011_010, 9'b010_100_101, 2'b11, 3'd0, 9, 2'b00, 3'd0, 9};
    tbl[3] = '{4, 9'b001_111_001, 9'b000_000_000, 2'b01, 3'd1, 3, 2'b01, 3'd1, 9};
    tbl[4] = '{5, 9'b000_111_000, 9'b000_111_000, 2'b01, 3'd1, 3, 2'b01, 3'd1, 9};
    tbl[5] = '{6, 9'b000_000_000, 9'b000_000_000, 2'b00, 3'd0, 9, 2'b00, 3'd0, 9};
    tbl[6] = '{7, 9'b100_000_001, 9'b010_010_010, 2'b10, 3'd4, 6, 2'b10, 3'd4, 9};

    repeat (2) @(posedge clk);
    #1;
    check("reset_a", obs_a(), 8'h00);
    check("reset_b", obs_b(), 8'h00);
    @(negedge clk);
    rst_n = 1'b1;

    foreach (tbl[i]) run_vec(tbl[i], (i < 2));

    // clear_game and board_valid on the same edge mid-scan: clear wins, no done pulse.
    start_long_scan();
    clear_game = 1'b1;
    board_p1 = 9'b000_000_111;
    board_valid = 1'b1;
    @(posedge clk); #1;
    clear_game = 1'b0;
    board_valid = 1'b0;
    for (int t = 0; t < 10; t++) begin
      check($sformatf("clrvalid_a_t%0d", t), obs_a(), 8'h00);
      check($sformatf("clrvalid_b_t%0d", t), obs_b(), 8'h00);
      @(posedge clk); #1;
    end

    // Asynchronous reset mid-scan.
    start_long_scan();
    #3;
    rst_n = 1'b0;
    #1;
    check("rst_mid_a", obs_a(), 8'h00);
    check("rst_mid_b", obs_b(), 8'h00);
    @(negedge clk);
    rst_n = 1'b1;
    for (int t = 0; t < 10; t++) begin
      @(posedge clk); #1;
      check($sformatf("post_rst_a_t%0d", t), obs_a(), 8'h00);
      check($sformatf("post_rst_b_t%0d", t), obs_b(), 8'h00);
    end
    run_vec(tbl[0], 1'b0);

    for (int n = 0; n < 40; n++) begin
      logic [8:0] p1 = '0;
      logic [8:0] p2 = '0;
      for (int c = 0; c < 9; c++) begin
        int r = (n % 2 == 0) ? int'($urandom_range(1, 7)) : int'($urandom_range(0, 7));
        if (r inside {1, 2, 3, 7}) p1[c] = 1'b1;
        if (r inside {4, 5, 6, 7}) p2[c] = 1'b1;
      end
      if (n % 3 == 0) p1 = p1 & ~p2;
      run_vec(model(100 + n, p1, p2), n[0]);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/win_detector.md
Name: win_detector

Overview:
- Upstream of the RGB LED status stage in the 3-in-a-row game.
- Captures a committed board snapshot and scans the 8 winning lines sequentially, one line per clock.
- Produces the registered 2-bit detect_win result that drives the LED stage directly.
- Holds the result until the game is cleared.

Parameters:
EARLY_EXIT, 1, 1 = stop scanning on the first hit; 0 = always scan all 8 lines and keep the first hit.
DRAW_ENABLE, 1, 1 = report a draw (2'b11) on a full board with no line; 0 = report 2'b00 instead.

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
board_p1  input  9  player-1 occupancy; bit i = cell row*3+col
board_p2  input  9  player-2 occupancy, same indexing
board_valid  input  1  single-cycle pulse: board committed after a move
clear_game  input  1  synchronous pulse: new game, clears result
detect_win  output  2  00 none, 01 player 1 wins, 10 player 2 wins, 11 draw
win_line  output  3  index of the winning line; 0 when none or draw
busy  output  1  high while capturing or scanning
done  output  1  one-cycle pulse when detect_win/win_line update after a scan
game_over  output  1  high while detect_win != 00

Behaviour:
- Reset (rst_n low, asynchronous): all outputs 0, state IDLE, scan index 0, snapshot registers 0.
- Line table, cells listed:
  - 0:{0,1,2}, 1:{3,4,5}, 2:{6,7,8}
  - 3:{0,3,6}, 4:{1,4,7}, 5:{2,5,8}
  - 6:{0,4,8}, 7:{2,4,6}
- States: IDLE, SCAN, FINISH, HOLD.
- IDLE:
  - board_valid=1 and game_over=0 at edge N: snapshot both boards, idx=0, go to SCAN, busy=1 from edge N.
  - board_valid is ignored while busy=1 or game_over=1.
- SCAN: each cycle evaluates line idx against the snapshot.
  - Player 1 is checked before player 2, so overlapping occupancy resolves to 01.
  - Hit with EARLY_EXIT=1 on line k: at edge N+2+k, detect_win=01/10, win_line=k, done=1 for one cycle, busy=0, go to HOLD.
  - Hit with EARLY_EXIT=0: record only the first hit and continue scanning.
  - After line 7 is evaluated (edge N+8), go to FINISH.
- FINISH (evaluated for one cycle; updates at edge N+9), exactly one of:
  - Recorded hit: apply it, go to HOLD.
  - No hit, (p1|p2)==9'h1FF, DRAW_ENABLE=1: detect_win=11, win_line=0, go to HOLD.
  - Otherwise: detect_win stays 00, go to IDLE.
  - done=1 and busy=0 at edge N+9 in all three cases.
- HOLD: outputs frozen; game_over=1; board_valid ignored.
- clear_game (any state, synchronous):
  - Next edge: detect_win=00, win_line=0, game_over=0, done=0, busy=0, state IDLE.
  - Aborts any scan in progress.
  - Has priority over a simultaneous board_valid; that board_valid is dropped.
- Snapshot isolation: board_p1/board_p2 may change during SCAN without affecting the result.
- rst_n asserted mid-scan: immediate return to reset values; no done pulse.

Test Plan:
1. Reset, then board_p1=9'b000000111, board_p2=9'b000011000, board_valid pulse at edge N -> edge N+2: detect_win=01, win_line=0, done=1 for one cycle, game_over=1.
2. board_p2=9'b001010100 (line 7), board_p1=9'b000000011 -> edge N+9: detect_win=10, win_line=7, busy high edges N..N+8.
3. Full board p1=9'b011000111^..., concretely p1=9'b010110101? Use p1=9'b101011010, p2=9'b010100101 (no line) -> edge N+9: detect_win=11, win_line=0; with DRAW_ENABLE=0 -> detect_win=00, game_over=0.
4. board_valid during SCAN, and board_valid in HOLD -> no restart and no output change; clear_game in HOLD -> detect_win=00 next edge, and a following board_valid is accepted.
5. clear_game and board_valid asserted on the same edge mid-scan -> IDLE, busy=0, no done pulse; rst_n low mid-scan -> all outputs 0 immediately.
6. EARLY_EXIT=0 with p1 holding lines 1 and 3 (p1=9'b001111001) -> result only at edge N+9: detect_win=01, win_line=1.
